// File: rtl/enc_readout.sv
// Encoder frame readout: streams a header, the Z period, then bank A and bank B
// capture memory contents to a valid/ready sink, and clears memory afterwards.
module enc_readout #(
  parameter int unsigned RD_LAT  = 3,
  parameter logic [15:0] HDR_TAG = 16'hA5A5
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Done,
  input  logic [15:0] PPR,
  input  logic [31:0] ZCounter,
  input  logic [31:0] q,
  input  logic        DataReady,
  output logic [1:0]  MemSlave,
  output logic [13:0] RetAddr,
  output logic        memCLR,
  output logic [31:0] DataOut,
  output logic        DataValid,
  output logic        Busy
);

  localparam int unsigned AW = 14;
  localparam int unsigned LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LW-1:0] LAST_LAT = LW'(RD_LAT - 1);
  localparam logic [1:0] BANK_NONE = 2'b00;
  localparam logic [1:0] BANK_A    = 2'b10;
  localparam logic [1:0] BANK_B    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_ZCNT, S_ADDR, S_WAIT, S_SEND, S_CLR
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   ppr_q, ppr_d;
  logic [31:0]   zc_q, zc_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [1:0]    mem_slave_q, mem_slave_d;
  logic [AW-1:0] ret_addr_q, ret_addr_d;
  logic [31:0]   data_out_q, data_out_d;
  logic          mem_clr_q, mem_clr_d;
  logic          data_valid_q, data_valid_d;
  logic          busy_q, busy_d;

  logic          xfer;
  logic          n_zero;
  logic [AW-1:0] last_addr;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q      <= S_IDLE;
      ppr_q        <= '0;
      zc_q         <= '0;
      lat_q        <= '0;
      mem_slave_q  <= BANK_NONE;
      ret_addr_q   <= '0;
      data_out_q   <= '0;
      mem_clr_q    <= 1'b0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ppr_q        <= ppr_d;
      zc_q         <= zc_d;
      lat_q        <= lat_d;
      mem_slave_q  <= mem_slave_d;
      ret_addr_q   <= ret_addr_d;
      data_out_q   <= data_out_d;
      mem_clr_q    <= mem_clr_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ppr_d       = ppr_q;
    zc_d        = zc_q;
    lat_d       = lat_q;
    mem_slave_d = mem_slave_q;
    ret_addr_d  = ret_addr_q;
    data_out_d  = data_out_q;

    xfer   = data_valid_q && DataReady;
    n_zero = (ppr_q == 16'd0);
    // Word count saturates at the 16K address space of each bank.
    last_addr = (ppr_q > 16'd16384) ? 14'h3FFF : AW'(ppr_q - 16'd1);

    case (state_q)
      S_IDLE: begin
        if (Done) begin
          ppr_d      = PPR;
          zc_d       = ZCounter;
          data_out_d = {HDR_TAG, PPR};
          state_d    = S_HDR;
        end
      end
      S_HDR: begin
        if (xfer) begin
          data_out_d = zc_q;
          state_d    = S_ZCNT;
        end
      end
      S_ZCNT: begin
        if (xfer) begin
          if (n_zero) begin
            state_d = S_CLR;
          end else begin
            mem_slave_d = BANK_A;
            ret_addr_d  = '0;
            lat_d       = '0;
            state_d     = S_ADDR;
          end
        end
      end
      S_ADDR, S_WAIT: begin
        if (lat_q == LAST_LAT) begin
          data_out_d = q;
          state_d    = S_SEND;
        end else begin
          lat_d   = LW'(lat_q + 1'b1);
          state_d = S_WAIT;
        end
      end
      S_SEND: begin
        if (xfer) begin
          lat_d   = '0;
          state_d = S_ADDR;
          if (ret_addr_q < last_addr) begin
            ret_addr_d = AW'(ret_addr_q + 1'b1);
          end else if (mem_slave_q == BANK_A) begin
            mem_slave_d = BANK_B;
            ret_addr_d  = '0;
          end else begin
            state_d = S_CLR;
          end
        end
      end
      S_CLR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Bank select is released as soon as the readout phase ends.
    if (state_d == S_CLR || state_d == S_IDLE) begin
      mem_slave_d = BANK_NONE;
      ret_addr_d  = '0;
    end

    mem_clr_d    = (state_d == S_CLR);
    data_valid_d = (state_d == S_HDR) || (state_d == S_ZCNT) || (state_d == S_SEND);
    busy_d       = (state_d != S_IDLE);
  end

  assign MemSlave  = mem_slave_q;
  assign RetAddr   = ret_addr_q;
  assign memCLR    = mem_clr_q;
  assign DataOut   = data_out_q;
  assign DataValid = data_valid_q;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_enc_readout.sv
// Randomized bench for enc_readout: frame contents are predicted from the
// latched PPR/ZCounter and a latency-accurate capture memory model.
module tb_enc_readout;

  localparam int unsigned RD_LAT = 3;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Done;
  logic [15:0] PPR;
  logic [31:0] ZCounter;
  logic [31:0] q;
  logic        DataReady;
  logic [1:0]  MemSlave;
  logic [13:0] RetAddr;
  logic        memCLR;
  logic [31:0] DataOut;
  logic        DataValid;
  logic        Busy;

  enc_readout #(.RD_LAT(RD_LAT), .HDR_TAG(16'hA5A5)) u_dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Done      (Done),
    .PPR       (PPR),
    .ZCounter  (ZCounter),
    .q         (q),
    .DataReady (DataReady),
    .MemSlave  (MemSlave),
    .RetAddr   (RetAddr),
    .memCLR    (memCLR),
    .DataOut   (DataOut),
    .DataValid (DataValid),
    .Busy      (Busy)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Memory word encodes bank, a per-frame seed and the address.
  function automatic logic [31:0] mem_word(input logic [1:0] ms, input logic [13:0] a,
                                           input logic [9:0] s);
    logic [7:0] tag;
    tag = (ms == 2'b11) ? 8'hBB : ((ms == 2'b10) ? 8'hAA : 8'h00);
    return {tag, s, a};
  endfunction

  // Capture memory: data for an address is ready RD_LAT edges after it is applied.
  logic [9:0]  seed = 10'd0;
  logic [31:0] mem_pipe [RD_LAT-1];
  always @(posedge Clk) begin
    mem_pipe[0] <= mem_word(MemSlave, RetAddr, seed);
    for (int i = 1; i < RD_LAT - 1; i++) mem_pipe[i] <= mem_pipe[i-1];
  end
  assign q = mem_pipe[RD_LAT-2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic [31:0] exp_q [$];
  logic [31:0] obs_q [$];
  int          clr_cnt, bank_a_cnt, max_addr, ms_seen, lat_run;
  bit          stalled;
  logic [31:0] prev_word;

  always @(negedge Clk) begin
    if (!Rst) begin
      if (stalled) begin
        chk("stall_valid", 32'(DataValid), 32'd1);
        chk("stall_data", DataOut, prev_word);
      end
      if (!Busy) begin
        chk("idle_memslave", 32'(MemSlave), 32'd0);
        chk("idle_valid", 32'(DataValid), 32'd0);
      end
      if (memCLR) begin
        clr_cnt++;
        chk("clr_memslave", 32'(MemSlave), 32'd0);
        chk("clr_all_sent", 32'(exp_q.size()), 32'd0);
      end
      if (MemSlave != 2'b00) ms_seen++;
      if (MemSlave == 2'b10 && DataValid && DataReady) begin
        bank_a_cnt++;
        if (int'(RetAddr) > max_addr) max_addr = int'(RetAddr);
      end
      if (Busy && !DataValid && MemSlave != 2'b00) begin
        lat_run++;
      end else begin
        if (DataValid && lat_run != 0) chk("read_latency", 32'(lat_run), 32'(RD_LAT));
        lat_run = 0;
      end
      if (DataValid && DataReady) begin
        obs_q.push_back(DataOut);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got %h expected no word", DataOut);
        end else begin
          chk("word", DataOut, exp_q.pop_front());
        end
      end
      stalled   = DataValid && !DataReady;
      prev_word = DataOut;
    end else begin
      stalled = 1'b0;
      lat_run = 0;
    end
  end

  // 0: always ready, 1: random ready, 2: five stall cycles per word.
  int ready_mode = 0;
  initial begin
    int sc;
    sc = 0;
    DataReady = 1'b1;
    forever begin
      @(posedge Clk);
      #1;
      case (ready_mode)
        0: DataReady = 1'b1;
        1: DataReady = 1'($urandom_range(0, 1));
        default: begin
          if (DataValid && sc < 5) begin
            DataReady = 1'b0;
            sc++;
          end else if (DataValid) begin
            DataReady = 1'b1;
            sc = 0;
          end else begin
            DataReady = 1'b0;
            sc = 0;
          end
        end
      endcase
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic start_frame(input logic [15:0] ppr, input logic [31:0] zc);
    int n;
    n = (int'(ppr) > 16384) ? 16384 : int'(ppr);
    seed = 10'($urandom);
    exp_q.delete();
    obs_q.delete();
    clr_cnt = 0; bank_a_cnt = 0; max_addr = 0; ms_seen = 0;
    exp_q.push_back({16'hA5A5, ppr});
    exp_q.push_back(zc);
    for (int i = 0; i < n; i++) exp_q.push_back(mem_word(2'b10, 14'(i), seed));
    for (int i = 0; i < n; i++) exp_q.push_back(mem_word(2'b11, 14'(i), seed));
    PPR = ppr;
    ZCounter = zc;
    Done = 1'b1;
    cyc(1);
    Done = 1'b0;
    PPR = 16'($urandom);
    ZCounter = $urandom;
  endtask

  task automatic finish_frame(input string name, input int budget);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || clr_cnt == 0) && t < budget) begin
      cyc(1);
      t++;
    end
    if (t >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d words left expected 0", name, exp_q.size());
    end
    cyc(2);
    chk({name, "_busy_end"}, 32'(Busy), 32'd0);
    chk({name, "_clr_count"}, 32'(clr_cnt), 32'd1);
  endtask

  initial begin
    logic [31:0] w;
    int t;
    Rst = 1'b1; Done = 1'b0; PPR = '0; ZCounter = '0;
    cyc(3);
    chk("rst_memslave", 32'(MemSlave), 32'd0);
    chk("rst_retaddr", 32'(RetAddr), 32'd0);
    chk("rst_memclr", 32'(memCLR), 32'd0);
    chk("rst_dataout", DataOut, 32'd0);
    chk("rst_valid", 32'(DataValid), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    Rst = 1'b0;
    cyc(5);
    chk("idle_wait_busy", 32'(Busy), 32'd0);

    // PPR=3, ready tied high
    ready_mode = 0;
    start_frame(16'd3, 32'd1000);
    finish_frame("ppr3", 500);
    chk("ppr3_len", 32'(obs_q.size()), 32'd8);
    if (obs_q.size() == 8) begin
      chk("ppr3_hdr", obs_q[0], 32'hA5A50003);
      chk("ppr3_zc", obs_q[1], 32'd1000);
      w = obs_q[2];
      chk("ppr3_a0_bank", 32'(w[31:24]), 32'hAA);
      chk("ppr3_a0_addr", 32'(w[13:0]), 32'd0);
      w = obs_q[7];
      chk("ppr3_b2_bank", 32'(w[31:24]), 32'hBB);
      chk("ppr3_b2_addr", 32'(w[13:0]), 32'd2);
    end

    // PPR=0: header and ZCounter only
    start_frame(16'd0, 32'h0BAD_F00D);
    finish_frame("ppr0", 100);
    chk("ppr0_len", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() == 2) chk("ppr0_hdr", obs_q[0], 32'hA5A50000);
    chk("ppr0_no_bank", 32'(ms_seen), 32'd0);

    // PPR=2 with five stall cycles on every word
    ready_mode = 2;
    start_frame(16'd2, 32'h1234_5678);
    finish_frame("stall", 1000);
    chk("stall_len", 32'(obs_q.size()), 32'd6);

    // Second Done during bank A is ignored
    ready_mode = 0;
    start_frame(16'd5, 32'd777);
    t = 0;
    while (MemSlave != 2'b10 && t < 200) begin cyc(1); t++; end
    chk("dup_reached_bank_a", 32'(MemSlave), 32'h2);
    PPR = 16'd7; ZCounter = 32'd1; Done = 1'b1;
    cyc(1);
    Done = 1'b0;
    finish_frame("dup", 1000);
    chk("dup_len", 32'(obs_q.size()), 32'd12);
    cyc(20);
    chk("dup_no_second_frame", 32'(Busy), 32'd0);
    chk("dup_single_clr", 32'(clr_cnt), 32'd1);

    // Random frames with random backpressure
    ready_mode = 1;
    for (int k = 0; k < 6; k++) begin
      start_frame(16'($urandom_range(0, 6)), $urandom);
      finish_frame("rand", 2000);
    end

    // PPR=20000 saturates; reset during bank B abandons the frame
    ready_mode = 0;
    start_frame(16'd20000, 32'hCAFE_0001);
    t = 0;
    while (MemSlave != 2'b11 && t < 70000) begin cyc(1); t++; end
    chk("big_reached_bank_b", 32'(MemSlave), 32'h3);
    if (obs_q.size() > 0) chk("big_hdr", obs_q[0], 32'hA5A54E20);
    chk("big_bank_a_words", 32'(bank_a_cnt), 32'd16384);
    chk("big_last_addr", 32'(max_addr), 32'd16383);
    cyc(10);
    Rst = 1'b1;
    @(negedge Clk);
    chk("mid_rst_memslave", 32'(MemSlave), 32'd0);
    chk("mid_rst_retaddr", 32'(RetAddr), 32'd0);
    chk("mid_rst_memclr", 32'(memCLR), 32'd0);
    chk("mid_rst_dataout", DataOut, 32'd0);
    chk("mid_rst_valid", 32'(DataValid), 32'd0);
    chk("mid_rst_busy", 32'(Busy), 32'd0);
    chk("mid_rst_no_clr", 32'(clr_cnt), 32'd0);
    cyc(2);
    Rst = 1'b0;
    exp_q.delete();
    cyc(5);
    chk("post_rst_idle", 32'(Busy), 32'd0);
    chk("post_rst_no_clr", 32'(clr_cnt), 32'd0);
    start_frame(16'd1, 32'd42);
    finish_frame("fresh", 200);
    chk("fresh_len", 32'(obs_q.size()), 32'd4);
    if (obs_q.size() > 0) chk("fresh_hdr", obs_q[0], 32'hA5A50001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
